// File: rtl/seg_sched_pkg.sv
// rtl/seg_sched_pkg.sv - shared types, sizing helpers and constants for the digit scheduler
package seg_sched_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = $clog2(MAX_DIGITS);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [MAX_DIGITS-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// rtl/seg_display_scheduler_if.sv - valid/ready update port carrying digit values and enable mask
interface seg_display_scheduler_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    updValid;
  logic                    updReady;
  logic [4*NUM_DIGITS-1:0] updData;
  logic [NUM_DIGITS-1:0]   updMask;

  modport master (output updValid, updData, updMask, input updReady);
  modport slave  (input updValid, updData, updMask, output updReady);
endinterface

// File: rtl/seg_next_digit.sv
// rtl/seg_next_digit.sv - picks the next enabled digit above the current one, wrapping to the lowest
module seg_next_digit
  import seg_sched_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic [NUM_DIGITS-1:0] mask_i,
  input  logic [IDX_W-1:0]      cur_i,
  output logic [IDX_W-1:0]      next_o,
  output logic                  wrap_o,
  output logic                  none_o
);
  logic [IDX_W-1:0] above;
  logic [IDX_W-1:0] low;
  logic             found_above;
  logic             found_low;

  // Descending scan so the last hit in each category is the lowest index.
  always_comb begin
    above       = '0;
    low         = '0;
    found_above = 1'b0;
    found_low   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        low       = IDX_W'(i);
        found_low = 1'b1;
        if (i > int'(cur_i)) begin
          above       = IDX_W'(i);
          found_above = 1'b1;
        end
      end
    end
  end

  assign next_o = found_above ? above : low;
  assign wrap_o = ~found_above;
  assign none_o = ~found_low;

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - blanked, frame-synchronous multiplexer sharing one seven-segment decoder
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int                    NUM_DIGITS   = 2,
  parameter int                    DWELL_CYCLES = 100000,
  parameter int                    BLANK_CYCLES = 2000,
  parameter logic [NUM_DIGITS-1:0] INIT_MASK    = '1
) (
  input  logic                   clk,
  input  logic                   nreset,
  seg_display_scheduler_if.slave upd,
  output logic [3:0]             hexOut,
  output logic [NUM_DIGITS-1:0]  segEn,
  output logic                   frameDone
);
  localparam int              CNT_W      = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
  logic                    pend_q, pend_d;
  logic                    frame_q, frame_d;

  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic             act_none;
  logic             cnt_last;
  logic             boundary;
  logic             fire;

  seg_next_digit #(.NUM_DIGITS(NUM_DIGITS)) u_next (
    .mask_i (act_mask_q),
    .cur_i  (idx_q),
    .next_o (nxt_idx),
    .wrap_o (nxt_wrap),
    .none_o (act_none)
  );

  assign fire         = upd.updValid & ~pend_q;
  assign upd.updReady = ~pend_q;
  assign cnt_last     = (state_q == SHOW) ? (cnt_q == DWELL_LAST) : (cnt_q == BLANK_LAST);
  // An empty mask never leaves BLANK, so each blank expiry doubles as a frame boundary.
  assign boundary     = cnt_last & ((state_q == SHOW) ? nxt_wrap : act_none);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      act_val_q   <= '0;
      act_mask_q  <= INIT_MASK;
      pend_val_q  <= '0;
      pend_mask_q <= '0;
      pend_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_mask_q  <= act_mask_d;
      pend_val_q  <= pend_val_d;
      pend_mask_q <= pend_mask_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    act_val_d   = act_val_q;
    act_mask_d  = act_mask_q;
    pend_val_d  = pend_val_q;
    pend_mask_d = pend_mask_q;
    pend_d      = pend_q;
    frame_d     = boundary;
    if (cnt_last) begin
      cnt_d = '0;
      if (state_q == SHOW) begin
        state_d = BLANK;
        idx_d   = nxt_idx;
      end else if (!act_none) begin
        state_d = SHOW;
      end
      // Pending values swap in only here, so the new frame starts from the new mask's lowest digit.
      if (boundary && pend_q) begin
        act_val_d  = pend_val_q;
        act_mask_d = pend_mask_q;
        idx_d      = lowest_idx(MAX_DIGITS'(pend_mask_q));
        pend_d     = 1'b0;
      end
    end
    if (fire) begin
      pend_val_d  = upd.updData;
      pend_mask_d = upd.updMask;
      pend_d      = 1'b1;
    end
  end

  always_comb begin
    hexOut = '0;
    segEn  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx_q) == i) begin
        hexOut   = act_val_q[4*i +: 4];
        segEn[i] = (state_q == SHOW);
      end
    end
  end

  assign frameDone = frame_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - randomized bench against a frame-list reference model
module tb_seg_display_scheduler;
  localparam int N  = 2;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int VW = 4 * N;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic [3:0]   hexOut;
  logic [N-1:0] segEn;
  logic         frameDone;

  seg_display_scheduler_if #(.NUM_DIGITS(N)) upd ();

  seg_display_scheduler #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .upd       (upd),
    .hexOut    (hexOut),
    .segEn     (segEn),
    .frameDone (frameDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] en;
    logic [3:0]   hex;
    logic         fd;
  } exp_t;

  // Model: one queued entry per expected cycle of the current frame.
  exp_t          q[$];
  logic [VW-1:0] m_val, m_pval;
  logic [N-1:0]  m_mask, m_pmask;
  logic          m_pend;

  logic          drv_valid, drv_rst, last_fire;
  logic [VW-1:0] drv_data;
  logic [N-1:0]  drv_mask;
  logic [N-1:0]  prev_en;
  logic [3:0]    prev_hex;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [N-1:0] en, input logic [3:0] hex, input logic fd);
    exp_t e;
    e.en  = en;
    e.hex = hex;
    e.fd  = fd;
    q.push_back(e);
  endfunction

  function automatic void build_frame(input logic fd);
    logic first;
    logic any;
    first = fd;
    any   = 1'b0;
    for (int d = 0; d < N; d++) begin
      if (m_mask[d]) begin
        any = 1'b1;
        for (int c = 0; c < BL; c++) begin
          push_exp('0, m_val[4*d +: 4], first);
          first = 1'b0;
        end
        for (int c = 0; c < DW; c++) push_exp(N'(1) << d, m_val[4*d +: 4], 1'b0);
      end
    end
    if (!any) begin
      for (int c = 0; c < BL; c++) begin
        push_exp('0, m_val[3:0], first);
        first = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_val  = '0;
    m_mask = '1;
    m_pend = 1'b0;
    q.delete();
    build_frame(1'b0);
  endfunction

  // Check the current cycle, drive inputs for the next edge, then advance the model across it.
  task automatic cycle();
    exp_t e;
    logic fire;
    @(negedge clk);
    e = q[0];
    check_eq("segEn", 32'(segEn), 32'(e.en));
    check_eq("hexOut", 32'(hexOut), 32'(e.hex));
    check_eq("frameDone", 32'(frameDone), 32'(e.fd));
    check_eq("updReady", 32'(upd.updReady), 32'(!m_pend));
    check_eq("onehot0", 32'($onehot0(segEn)), 32'(1));
    if (segEn != '0 && segEn == prev_en) check_eq("hex_stable", 32'(hexOut), 32'(prev_hex));
    prev_en  = segEn;
    prev_hex = hexOut;

    nreset       = !drv_rst;
    upd.updValid = drv_valid;
    upd.updData  = drv_data;
    upd.updMask  = drv_mask;

    if (drv_rst) begin
      model_reset();
      last_fire = 1'b0;
    end else begin
      fire = drv_valid & !m_pend;
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (m_pend) begin
          m_val  = m_pval;
          m_mask = m_pmask;
          m_pend = 1'b0;
        end
        build_frame(1'b1);
      end
      if (fire) begin
        m_pval  = drv_data;
        m_pmask = drv_mask;
        m_pend  = 1'b1;
      end
      last_fire = fire;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send(input logic [VW-1:0] data, input logic [N-1:0] mask);
    drv_valid = 1'b1;
    drv_data  = data;
    drv_mask  = mask;
    last_fire = 1'b0;
    for (int k = 0; k < 100 && !last_fire; k++) cycle();
    check_eq("send_accepted", 32'(last_fire), 32'(1));
    drv_valid = 1'b0;
  endtask

  initial begin
    upd.updValid = 1'b0;
    upd.updData  = '0;
    upd.updMask  = '0;
    drv_valid = 1'b0;
    drv_data  = '0;
    drv_mask  = '0;
    drv_rst   = 1'b1;
    last_fire = 1'b0;
    prev_en   = '0;
    prev_hex  = '0;
    m_pval    = '0;
    m_pmask   = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);

    cycle();
    drv_rst = 1'b0;
    run(30);

    run(5);
    send(8'h3A, 2'b11);
    run(30);

    send(8'h5C, 2'b10);
    run(30);
    send(8'hE7, 2'b00);
    run(20);

    for (int k = 0; k < 50 && q.size() != 1; k++) cycle();
    check_eq("boundary_found", 32'(q.size()), 32'(1));
    send(8'h71, 2'b11);
    send(8'h94, 2'b01);
    run(40);

    for (int k = 0; k < 50 && q[0].en == '0; k++) cycle();
    check_eq("show_found", 32'(q[0].en != '0), 32'(1));
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    run(20);

    for (int k = 0; k < 10000; k++) begin
      if (last_fire) drv_valid = 1'b0;
      if (!drv_valid && $urandom_range(0, 15) == 0) begin
        drv_valid = 1'b1;
        drv_data  = VW'($urandom);
        drv_mask  = N'($urandom);
      end
      drv_rst = ($urandom_range(0, 1999) == 0);
      cycle();
    end
    drv_rst = 1'b0;
    drv_valid = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Time-multiplexes one shared seven-segment decoder across NUM_DIGITS common-enable digits.
- Each enabled digit gets a fixed dwell slot. A blanking gap between slots suppresses ghosting.
- Digit values and the enable mask arrive over a valid/ready update port. They are double-buffered and applied only at frame boundaries, so a frame never tears.
- Sits between the keypad/value logic and the decoder, replacing the fixed two-digit divided-clock multiplexing.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; range 1..8.
- DWELL_CYCLES, 100000, clk cycles a digit enable is asserted per slot; must be ≥1.
- BLANK_CYCLES, 2000, clk cycles with all enables low between slots; must be ≥1.
- INIT_MASK, all ones, digit-enable mask loaded at reset.

Ports:
- clk  input  1  system clock.
- nreset  input  1  synchronous active-low reset.
- updValid  input  1  update request.
- updReady  output  1  update port can accept.
- updData  input  4*NUM_DIGITS  hex values; digit i is bits [4i+3:4i].
- updMask  input  NUM_DIGITS  per-digit enable for the update.
- hexOut  output  4  value to the shared seven-segment decoder.
- segEn  output  NUM_DIGITS  one-hot digit enables, active-high.
- frameDone  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset is synchronous to clk, active-low. While nreset=0 on a rising edge:
  - state=BLANK, digit index=0, counter=0;
  - segEn=0, hexOut=0, frameDone=0, updReady=1;
  - active values=0, active mask=INIT_MASK, pending flag cleared.
  - Reset mid-slot aborts the slot immediately; enables drop on the first reset edge.
- State machine has two states:
  - BLANK: segEn=0; hexOut = active value of the upcoming digit, so the decoder settles before enable. Lasts exactly BLANK_CYCLES, then SHOW.
  - SHOW: segEn has only the current digit bit set; hexOut = its active value. Lasts exactly DWELL_CYCLES, then BLANK.
- Single down/up counter, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1), reloaded on each state change.
- Digit order:
  - Ascending index, visiting only digits whose active mask bit is 1.
  - Next digit is the lowest enabled index above the current one. If none, wrap to the lowest enabled index; that wrap is a frame boundary.
  - With NUM_DIGITS=1 or a single enabled digit, every SHOW→BLANK transition is a frame boundary.
- Empty mask (all zero):
  - Stay in BLANK with segEn=0 indefinitely.
  - Each BLANK_CYCLES expiry is treated as a frame boundary, so updates can still apply.
- Frame boundary, on the transition edge:
  - If pending is set: active values and mask ← pending registers; pending cleared. The next digit is then chosen from the NEW mask, lowest enabled index.
  - frameDone=1 for exactly the following cycle, the first BLANK cycle of the new frame.
- Update handshake:
  - updReady = ~pending.
  - Transfer occurs when updValid & updReady: updData and updMask are captured into the pending registers and pending is set. updReady falls the next cycle.
  - updValid while updReady=0 is ignored; the sender must hold.
- Simultaneous events:
  - A transfer in the same cycle as a boundary edge is NOT applied at that boundary; it applies at the next one.
  - Pending release and a new transfer cannot coincide, because updReady=0 while pending.
- Latency: an accepted update is visible on hexOut no later than one full frame plus one slot, i.e. ≤ (NUM_DIGITS+1)·(DWELL_CYCLES+BLANK_CYCLES) cycles.
- Invariants:
  - segEn is never multi-hot.
  - segEn is never high during BLANK.
  - hexOut changes only at a state-change edge or an applied update, never mid-SHOW.

Decomposition:
- Package seg_sched_pkg:
  - state typedef enum {BLANK, SHOW};
  - localparam function for counter width;
  - MAX_DIGITS=8 constant.
- Sub-module seg_next_digit (combinational):
  - inputs: mask, current index;
  - outputs: next enabled index, wrap flag, none-enabled flag.
- The top holds the FSM, counter, active/pending registers and handshake.

Test Plan:
- Reset with DWELL=4, BLANK=2, NUM_DIGITS=2, values 0 → segEn pattern repeats with a 12-cycle period: 00,00,01×4,00,00,10×4. frameDone pulses every 12 cycles, aligned to the first BLANK after digit 1's SHOW.
- Update {data=0x3A, mask=11} mid-frame → updReady low the next cycle. Digit0 shows A and digit1 shows 3, starting at the next boundary. hexOut is unchanged before that. updReady returns high the cycle after the boundary.
- Update with mask=10 → after the boundary only segEn=10 appears, with a 6-cycle period. Then mask=00 → segEn stays 0 and frameDone pulses every 2 cycles.
- updValid asserted on the boundary edge cycle → values are applied at the following boundary, not the current one. A second updValid while pending is held off until updReady=1.
- nreset=0 during a SHOW cycle → segEn=0, hexOut=0 and updReady=1 after that edge. After release, the sequence restarts at BLANK for digit 0 with the INIT_MASK and zero values.
- Random updates over 10k cycles (assertions) → segEn is always one-hot-or-zero, never high in BLANK, and hexOut is stable throughout each SHOW.
